// File: rtl/audio_ctrl_pkg.sv
// Shared definitions for the audio-in / audio-out FIFO controllers.
// Scheduler state codes, FIFO depth and the read_space fill-level decode.
package audio_ctrl_pkg;

    localparam int AUDIO_FIFO_DEPTH = 128;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_POP_L   = 2'd1;
    localparam state_t ST_POP_R   = 2'd2;
    localparam state_t ST_PRESENT = 2'd3;

    // [7] is the full flag; when set, the 7-bit used count has wrapped to 0.
    function automatic logic [7:0] fill_level(input logic [7:0] space);
        return space[7] ? 8'(AUDIO_FIFO_DEPTH) : {1'b0, space[6:0]};
    endfunction

endpackage

// File: rtl/audio_sat_event_counter.sv
// Rising-edge event counter on two flags: saturating +0/+1/+2 per cycle, sticky bit, clear.
// Latency: count/sticky update one cycle after the flag edge is sampled.
// Backpressure: none; an event in the same cycle as clear wins over the clear.
module audio_sat_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_a,
    input  logic             flag_b,
    input  logic             clear,
    output logic             sticky,
    output logic [WIDTH-1:0] count
);

    logic             prev_a;
    logic             prev_b;
    logic             rise_a;
    logic             rise_b;
    logic [1:0]       inc;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        rise_a     = flag_a & ~prev_a;
        rise_b     = flag_b & ~prev_b;
        inc        = {1'b0, rise_a} + {1'b0, rise_b};
        base       = clear ? '0 : count;
        sum        = {1'b0, base} + {{(WIDTH-1){1'b0}}, inc};
        count_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_a <= 1'b0;
            prev_b <= 1'b0;
            count  <= '0;
            sticky <= 1'b0;
        end else begin
            prev_a <= flag_a;
            prev_b <= flag_b;
            count  <= count_next;
            if (rise_a || rise_b)
                sticky <= 1'b1;
            else if (clear)
                sticky <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_in_pair_scheduler.sv
// Drains left/right deserializer FIFOs as stereo pairs and presents them downstream.
// Latency: 3 cycles from the IDLE decision to sample_valid; at most one pair per 4 cycles.
// Backpressure: pair is held stable while sample_valid && !sample_ready; no pops meanwhile.
module audio_in_pair_scheduler
    import audio_ctrl_pkg::*;
#(
    parameter int AUDIO_DATA_WIDTH = 32,
    parameter int MIN_FILL         = 1,
    parameter int OVF_CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear_status,
    input  logic [7:0]                  left_audio_fifo_read_space,
    input  logic [7:0]                  right_audio_fifo_read_space,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    output logic                        read_left_audio_data_en,
    output logic                        read_right_audio_data_en,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    output logic [AUDIO_DATA_WIDTH-1:0] sample_left,
    output logic [AUDIO_DATA_WIDTH-1:0] sample_right,
    output logic                        overflow_sticky,
    output logic [OVF_CNT_WIDTH-1:0]    overflow_count
);

    localparam logic [7:0] MIN_LEVEL = 8'(MIN_FILL);

    state_t     state;
    state_t     state_next;
    logic [7:0] left_level;
    logic [7:0] right_level;
    logic       pair_ready;

    always_comb begin
        left_level  = fill_level(left_audio_fifo_read_space);
        right_level = fill_level(right_audio_fifo_read_space);
        pair_ready  = enable && (left_level >= MIN_LEVEL) && (right_level >= MIN_LEVEL);
    end

    // PRESENT always returns through IDLE: read_space lags a pop by two cycles,
    // and the POP_R -> PRESENT -> IDLE path is exactly long enough to see fresh levels.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (pair_ready) state_next = ST_POP_L;
            ST_POP_L:   state_next = ST_POP_R;
            ST_POP_R:   state_next = ST_PRESENT;
            ST_PRESENT: if (sample_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Show-ahead FIFOs: the head word is captured on the same edge that pops it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_left  <= '0;
            sample_right <= '0;
        end else begin
            if (state == ST_POP_L)
                sample_left <= left_channel_data;
            if (state == ST_POP_R)
                sample_right <= right_channel_data;
        end
    end

    assign read_left_audio_data_en  = (state == ST_POP_L);
    assign read_right_audio_data_en = (state == ST_POP_R);
    assign sample_valid             = (state == ST_PRESENT);

    audio_sat_event_counter #(
        .WIDTH (OVF_CNT_WIDTH)
    ) u_overrun (
        .clk    (clk),
        .reset  (reset),
        .flag_a (left_audio_fifo_read_space[7]),
        .flag_b (right_audio_fifo_read_space[7]),
        .clear  (clear_status),
        .sticky (overflow_sticky),
        .count  (overflow_count)
    );

endmodule
